// File: rtl/us_param_pkg.sv
// us_param_pkg: parameter set type, opcodes and default/field helpers for us_param_bank
package us_param_pkg;

  typedef struct packed {
    logic [7:0]  accum;
    logic [15:0] delay;
    logic [2:0]  scan_type;
    logic [10:0] scan_len;
    logic [2:0]  sel;
    logic [10:0] start_amp;
    logic [9:0]  amp_porch;
    logic [19:0] ainc_one;
    logic [19:0] ainc_two;
    logic [15:0] vrc_len;
  } us_param_t;

  typedef enum logic {ST_IDLE, ST_SWEEP} sweep_state_t;

  localparam logic [3:0] OP_SCAN_LEN  = 4'h1;
  localparam logic [3:0] OP_AINC_ONE  = 4'h2;
  localparam logic [3:0] OP_AINC_TWO  = 4'h3;
  localparam logic [3:0] OP_VRC_LEN   = 4'h4;
  localparam logic [3:0] OP_ACCUM     = 4'h5;
  localparam logic [3:0] OP_DELAY     = 4'h6;
  localparam logic [3:0] OP_SCAN_TYPE = 4'h7;
  localparam logic [3:0] OP_START_AMP = 4'h9;
  localparam logic [3:0] OP_AMP_PORCH = 4'hA;
  localparam logic [3:0] OP_SEL       = 4'hB;
  localparam logic [3:0] OP_COMMIT    = 4'hC;
  localparam logic [3:0] OP_READ      = 4'hD;
  localparam logic [3:0] OP_RESTORE   = 4'hE;

  // Amplitude increments are {10-bit integer, 10-bit fraction}: {20,0} and {8,0}
  function automatic us_param_t param_default(input logic [2:0] ch);
    us_param_t p;
    p.accum     = 8'd10;
    p.delay     = 16'd0;
    p.scan_type = 3'd1;
    p.scan_len  = 11'd64;
    p.sel       = ch;
    p.start_amp = 11'd0;
    p.amp_porch = 10'd40;
    p.ainc_one  = {10'd20, 10'd0};
    p.ainc_two  = {10'd8, 10'd0};
    p.vrc_len   = 16'd150;
    return p;
  endfunction

  function automatic logic is_write(input logic [3:0] op);
    return op inside {OP_SCAN_LEN, OP_AINC_ONE, OP_AINC_TWO, OP_VRC_LEN, OP_ACCUM,
                      OP_DELAY, OP_SCAN_TYPE, OP_START_AMP, OP_AMP_PORCH, OP_SEL};
  endfunction

  function automatic us_param_t param_write(input us_param_t p_in, input logic [3:0] op,
                                            input logic [19:0] v);
    us_param_t p;
    p = p_in;
    case (op)
      OP_SCAN_LEN:  p.scan_len  = v[10:0];
      OP_AINC_ONE:  p.ainc_one  = v;
      OP_AINC_TWO:  p.ainc_two  = v;
      OP_VRC_LEN:   p.vrc_len   = v[15:0];
      OP_ACCUM:     p.accum     = v[7:0];
      OP_DELAY:     p.delay     = v[15:0];
      OP_SCAN_TYPE: p.scan_type = v[2:0];
      OP_START_AMP: p.start_amp = v[10:0];
      OP_AMP_PORCH: p.amp_porch = v[9:0];
      OP_SEL:       p.sel       = v[2:0];
      default:      p = p_in;
    endcase
    return p;
  endfunction

  // Unknown field codes read back as zero
  function automatic logic [19:0] param_field(input us_param_t p, input logic [3:0] op);
    case (op)
      OP_SCAN_LEN:  return 20'(p.scan_len);
      OP_AINC_ONE:  return p.ainc_one;
      OP_AINC_TWO:  return p.ainc_two;
      OP_VRC_LEN:   return 20'(p.vrc_len);
      OP_ACCUM:     return 20'(p.accum);
      OP_DELAY:     return 20'(p.delay);
      OP_SCAN_TYPE: return 20'(p.scan_type);
      OP_START_AMP: return 20'(p.start_amp);
      OP_AMP_PORCH: return 20'(p.amp_porch);
      OP_SEL:       return 20'(p.sel);
      default:      return 20'd0;
    endcase
  endfunction

endpackage

// File: rtl/us_param_commit_fsm.sv
// us_param_commit_fsm: IDLE/SWEEP commit sequencing, sweep pointer, ready flag and pending load
module us_param_commit_fsm
  import us_param_pkg::*;
#(
  parameter int NUM_CH = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            load,
  input  logic [CH_W-1:0] load_ch,
  output logic            ready,
  output logic            sweeping,
  output logic [CH_W-1:0] ptr,
  output logic            serve,
  output logic [CH_W-1:0] serve_ch
);

  sweep_state_t    state, state_nx;
  logic [CH_W-1:0] ptr_nx, pend_ch, pend_ch_nx;
  logic            pend, pend_nx;

  assign ready    = state == ST_IDLE;
  assign sweeping = state == ST_SWEEP;

  // State, sweep pointer and the 1-deep pending load register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      pend    <= 1'b0;
      pend_ch <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      pend    <= pend_nx;
      pend_ch <= pend_ch_nx;
    end
  end

  // Next state; a fresh load in IDLE supersedes a still-pending one
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    pend_nx    = pend;
    pend_ch_nx = pend_ch;
    serve      = 1'b0;
    serve_ch   = load_ch;
    case (state)
      ST_IDLE: begin
        serve    = load || pend;
        serve_ch = load ? load_ch : pend_ch;
        pend_nx  = 1'b0;
        if (start) begin
          state_nx = ST_SWEEP;
          ptr_nx   = '0;
        end
      end
      ST_SWEEP: begin
        pend_nx    = pend || load;
        pend_ch_nx = load ? load_ch : pend_ch;
        ptr_nx     = ptr + 1'b1;
        if (abort || ptr == CH_W'(NUM_CH - 1)) begin
          state_nx = ST_IDLE;
          ptr_nx   = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/us_param_bank.sv
// us_param_bank: staging/active per-channel parameter store; US_PARAM_READBACK_EN enables opcode D readback
module us_param_bank
  import us_param_pkg::*;
#(
  parameter int NUM_CH = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hw_ch,
  input  logic [31:0]     i_cmd_data,
  input  logic            i_cmd_vld,
  input  logic            i_load_param,
  input  logic [CH_W-1:0] i_sub_channel,
  output logic            o_ready,
  output logic            o_param_vld,
  output logic [7:0]      o_accum,
  output logic [15:0]     o_delay,
  output logic [2:0]      o_scan_type,
  output logic [10:0]     o_scan_len,
  output logic [2:0]      o_sel,
  output logic [10:0]     o_start_amp,
  output logic [9:0]      o_amp_porch,
  output logic [19:0]     o_ainc_one,
  output logic [19:0]     o_ainc_two,
  output logic [15:0]     o_vrc_len,
  output logic            o_cmd_err,
  output logic [31:0]     o_rd_data,
  output logic            o_rd_vld
);

  us_param_t       stag [NUM_CH];
  us_param_t       act  [NUM_CH];
  us_param_t       out;
  logic [3:0]      op;
  logic [19:0]     pl;
  logic [CH_W-1:0] ch, ptr, serve_ch;
  logic            hit, is_commit, wr_en, commit_one, commit_all, restore, rd_op, err_nx;
  logic            sweeping, serve;
  logic            unused_bits;

  assign op          = i_cmd_data[27:24];
  assign pl          = i_cmd_data[19:0];
  assign ch          = i_cmd_data[28 +: CH_W];
  assign unused_bits = ^i_cmd_data[23:20];
  assign hit         = i_cmd_vld && i_cmd_data[31] == i_hw_ch && (i_cmd_data[30:28] >> CH_W) == 3'd0;
`ifdef US_PARAM_READBACK_EN
  assign rd_op       = op == OP_READ;
`else
  assign rd_op       = 1'b0;
`endif
  assign is_commit   = hit && op == OP_COMMIT;
  assign wr_en       = hit && is_write(op);
  assign commit_one  = is_commit && !sweeping && !pl[0];
  assign commit_all  = is_commit && !sweeping && pl[0];
  assign restore     = hit && op == OP_RESTORE;
  assign err_nx      = (hit && !(is_write(op) || op == OP_COMMIT || op == OP_RESTORE || rd_op))
                    || (is_commit && sweeping);

  us_param_commit_fsm #(.NUM_CH(NUM_CH)) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (commit_all),
    .abort    (restore),
    .load     (i_load_param),
    .load_ch  (i_sub_channel),
    .ready    (o_ready),
    .sweeping (sweeping),
    .ptr      (ptr),
    .serve    (serve),
    .serve_ch (serve_ch)
  );

  // Banks: writes hit staging, commits and sweep copies read pre-write staging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stag[i] <= param_default(3'(i));
        act[i]  <= param_default(3'(i));
      end
    end else if (restore) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stag[i] <= param_default(3'(i));
        act[i]  <= param_default(3'(i));
      end
    end else begin
      if (wr_en) stag[ch] <= param_write(stag[ch], op, pl);
      if (commit_one) act[ch] <= stag[ch];
      if (sweeping) act[ptr] <= stag[ptr];
    end
  end

  // Output set and strobes; loads see the active bank before this cycle's commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out         <= param_default(3'd0);
      o_param_vld <= 1'b0;
      o_cmd_err   <= 1'b0;
    end else begin
      out         <= serve ? act[serve_ch] : out;
      o_param_vld <= serve;
      o_cmd_err   <= err_nx;
    end
  end

  assign o_accum     = out.accum;
  assign o_delay     = out.delay;
  assign o_scan_type = out.scan_type;
  assign o_scan_len  = out.scan_len;
  assign o_sel       = out.sel;
  assign o_start_amp = out.start_amp;
  assign o_amp_porch = out.amp_porch;
  assign o_ainc_one  = out.ainc_one;
  assign o_ainc_two  = out.ainc_two;
  assign o_vrc_len   = out.vrc_len;

`ifdef US_PARAM_READBACK_EN
  // Readback of one active field, zero-extended, one cycle after the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data <= '0;
      o_rd_vld  <= 1'b0;
    end else begin
      o_rd_vld  <= hit && rd_op;
      o_rd_data <= (hit && rd_op) ? {12'd0, param_field(act[ch], pl[3:0])} : o_rd_data;
    end
  end
`else
  assign o_rd_data = '0;
  assign o_rd_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_us_param_bank.sv
// tb_us_param_bank: randomized scoreboard bench for us_param_bank against an array-based model
module tb_us_param_bank;

  localparam int NUM_CH = 8;

  typedef struct packed {
    logic [7:0]  accum;
    logic [15:0] delay;
    logic [2:0]  scan_type;
    logic [10:0] scan_len;
    logic [2:0]  sel;
    logic [10:0] start_amp;
    logic [9:0]  amp_porch;
    logic [19:0] ainc_one;
    logic [19:0] ainc_two;
    logic [15:0] vrc_len;
  } pset_t;

  logic        clk = 1'b0, rst_n = 1'b0, hw = 1'b1, cmd_vld = 1'b0, load = 1'b0;
  logic [31:0] cmd = '0;
  logic [2:0]  sub = '0;
  logic        o_ready, o_param_vld, o_cmd_err, o_rd_vld;
  logic [7:0]  o_accum;
  logic [15:0] o_delay, o_vrc_len;
  logic [2:0]  o_scan_type, o_sel;
  logic [10:0] o_scan_len, o_start_amp;
  logic [9:0]  o_amp_porch;
  logic [19:0] o_ainc_one, o_ainc_two;
  logic [31:0] o_rd_data;
  pset_t       got;

  us_param_bank #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_hw_ch(hw), .i_cmd_data(cmd), .i_cmd_vld(cmd_vld),
    .i_load_param(load), .i_sub_channel(sub), .o_ready(o_ready), .o_param_vld(o_param_vld),
    .o_accum(o_accum), .o_delay(o_delay), .o_scan_type(o_scan_type), .o_scan_len(o_scan_len),
    .o_sel(o_sel), .o_start_amp(o_start_amp), .o_amp_porch(o_amp_porch),
    .o_ainc_one(o_ainc_one), .o_ainc_two(o_ainc_two), .o_vrc_len(o_vrc_len),
    .o_cmd_err(o_cmd_err), .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld)
  );

  assign got = {o_accum, o_delay, o_scan_type, o_scan_len, o_sel, o_start_amp,
                o_amp_porch, o_ainc_one, o_ainc_two, o_vrc_len};

  always #5 clk = ~clk;

  pset_t       stag [NUM_CH];
  pset_t       act  [NUM_CH];
  bit          swp, pend;
  int          sp, pch;
  pset_t       pq[$];
  bit          rq[$];
  bit          eq[$];
  logic [31:0] dq[$];
  int          n_cmp = 0, n_bad = 0;

  function automatic pset_t dflt(int c);
    pset_t p;
    p.accum = 8'd10; p.delay = 16'd0; p.scan_type = 3'd1; p.scan_len = 11'd64;
    p.sel = 3'(c); p.start_amp = 11'd0; p.amp_porch = 10'd40;
    p.ainc_one = 20'd20480; p.ainc_two = 20'd8192; p.vrc_len = 16'd150;
    return p;
  endfunction

  function automatic bit is_wr(int op);
    return (op >= 1 && op <= 7) || (op >= 9 && op <= 11);
  endfunction

  function automatic pset_t wr(pset_t p, int op, logic [19:0] v);
    case (op)
      1: p.scan_len = v[10:0];
      2: p.ainc_one = v;
      3: p.ainc_two = v;
      4: p.vrc_len = v[15:0];
      5: p.accum = v[7:0];
      6: p.delay = v[15:0];
      7: p.scan_type = v[2:0];
      9: p.start_amp = v[10:0];
      10: p.amp_porch = v[9:0];
      11: p.sel = v[2:0];
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] fld(pset_t p, int op);
    case (op)
      1: return 32'(p.scan_len);
      2: return 32'(p.ainc_one);
      3: return 32'(p.ainc_two);
      4: return 32'(p.vrc_len);
      5: return 32'(p.accum);
      6: return 32'(p.delay);
      7: return 32'(p.scan_type);
      9: return 32'(p.start_amp);
      10: return 32'(p.amp_porch);
      11: return 32'(p.sel);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(logic h, int c, int op, logic [19:0] v);
    return {h, 3'(c), 4'(op), 4'h0, v};
  endfunction

  task automatic check(string name, logic [127:0] actual, logic [127:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      stag[i] = dflt(i);
      act[i] = dflt(i);
    end
    swp = 0; sp = 0; pend = 0; pch = 0;
    pq.delete(); rq.delete(); eq.delete(); dq.delete();
  endtask

  // Drive one cycle from a negedge and record what the DUT must show after the next posedge
  task automatic step(bit v, logic [31:0] c, bit ld, int lc);
    bit was, hit, ok;
    int op, ch;
    logic [19:0] pl;
    cmd_vld = v; cmd = c; load = ld; sub = 3'(lc);
    was = swp;
    hit = v && c[31] == hw;
    op = int'(c[27:24]);
    ch = int'(c[30:28]);
    pl = c[19:0];
    if (!was) begin
      if (ld) pq.push_back(act[lc]);
      else if (pend) pq.push_back(act[pch]);
      pend = 0;
    end else if (ld) begin
      pend = 1;
      pch = lc;
    end
    ok = is_wr(op) || op == 12 || op == 14;
`ifdef US_PARAM_READBACK_EN
    ok = ok || op == 13;
    if (hit && op == 13) dq.push_back(fld(act[ch], int'(pl[3:0])));
`endif
    if (was) begin
      act[sp] = stag[sp];
      sp++;
      if (sp == NUM_CH) swp = 0;
    end
    if (hit) begin
      if (is_wr(op)) stag[ch] = wr(stag[ch], op, pl);
      if (op == 12 && !was) begin
        if (pl[0]) begin
          swp = 1;
          sp = 0;
        end else act[ch] = stag[ch];
      end
      if (op == 14) begin
        for (int i = 0; i < NUM_CH; i++) begin
          stag[i] = dflt(i);
          act[i] = dflt(i);
        end
        swp = 0;
      end
    end
    eq.push_back(hit && (!ok || (op == 12 && was)));
    rq.push_back(!swp);
    @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (rq.size() > 0) check("ready", o_ready, rq.pop_front());
      if (eq.size() > 0) check("cmd_err", o_cmd_err, eq.pop_front());
      if (o_param_vld) begin
        if (pq.size() > 0) check("param", got, pq.pop_front());
        else begin
          n_cmp++; n_bad++;
          $display("FAIL param_unexpected at %0t: got %h, expected no strobe", $time, got);
        end
      end
`ifdef US_PARAM_READBACK_EN
      if (o_rd_vld) begin
        if (dq.size() > 0) check("rd_data", o_rd_data, dq.pop_front());
        else begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected at %0t: got %h, expected no strobe", $time, o_rd_data);
        end
      end
`else
      check("rd_tied", {o_rd_vld, o_rd_data}, 33'd0);
`endif
    end
  end

  task automatic reset_checks(string tag);
    check({tag, "_ready"}, o_ready, 1'b1);
    check({tag, "_param_vld"}, o_param_vld, 1'b0);
    check({tag, "_cmd_err"}, o_cmd_err, 1'b0);
    check({tag, "_outputs"}, got, dflt(0));
    check({tag, "_rd"}, {o_rd_vld, o_rd_data}, 33'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    step(0, 0, 1, 3);
    step(1, mk(hw, 2, 1, 20'd200), 0, 0);
    step(0, 0, 1, 2);
    step(1, mk(hw, 2, 12, 20'd0), 0, 0);
    step(0, 0, 1, 2);
    step(1, mk(hw, 5, 6, 20'hBEEF), 0, 0);
    step(1, mk(hw, 0, 12, 20'd1), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 5);
    step(1, mk(hw, 0, 12, 20'd0), 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(1, mk(!hw, 4, 1, 20'd77), 0, 0);
    step(0, 0, 1, 4);
    step(1, mk(hw, 1, 15, 20'd0), 0, 0);
    step(1, mk(hw, 7, 5, 20'd99), 0, 0);
    step(1, mk(hw, 0, 12, 20'd1), 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, mk(hw, 0, 14, 20'd0), 0, 0);
    for (int i = 0; i < NUM_CH; i++) step(0, 0, 1, i);
    step(1, mk(hw, 1, 6, 20'h01234), 0, 0);
    step(1, mk(hw, 1, 12, 20'd0), 0, 0);
    step(1, mk(hw, 1, 13, 20'd6), 0, 0);
    step(0, 0, 0, 0);
    step(1, mk(hw, 3, 9, 20'd321), 0, 0);
    step(1, mk(hw, 0, 12, 20'd1), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    rst_n = 1'b0; cmd_vld = 1'b0; load = 1'b0;
    model_reset();
    #1;
    reset_checks("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);
    repeat (3000) begin
      logic h;
      h = ($urandom_range(0, 9) == 0) ? !hw : hw;
      step($urandom_range(0, 9) < 6, mk(h, $urandom_range(0, 7), $urandom_range(0, 15),
           20'($urandom)), $urandom_range(0, 9) < 3, $urandom_range(0, 7));
    end
    repeat (12) step(0, 0, 0, 0);
    check("param_drain", pq.size(), 0);
    check("rd_drain", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/us_param_bank.md
# us_param_bank

Per-channel ultrasonic acquisition parameter store, parametrised in channel count, with a staging/active double bank, so host command writes never tear a running scan. It sits between the host command decoder (32-bit command stream) and the scan sequencer. The sequencer loads one channel's active parameter set per scan. Staged values become active only on an explicit commit, either single-channel or an all-channel sweep.

## Interface
- NUM_CH, 8, number of sub-channels; power of two, 2..8
- CH_W, $clog2(NUM_CH), sub-channel index width (derived, not overridden)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_hw_ch  in  1  hardware channel id of this instance
- i_cmd_data  in  32  command word: [31] hw_ch, [30:28] channel (upper bits above CH_W must be 0, else ignored), [27:24] opcode, [19:0] payload
- i_cmd_vld  in  1  command strobe, one word per cycle
- i_load_param  in  1  load request strobe
- i_sub_channel  in  CH_W  channel to load
- o_ready  out  1  1 when no commit sweep is running
- o_param_vld  out  1  one-cycle pulse when the output set has been updated
- o_accum 8, o_delay 16, o_scan_type 3, o_scan_len 11, o_sel 3, o_start_amp 11, o_amp_porch 10, o_ainc_one 20, o_ainc_two 20, o_vrc_len 16  out  active parameter set
- o_cmd_err  out  1  one-cycle pulse on a rejected command
- o_rd_data  out  32  readback word (US_PARAM_READBACK_EN only)
- o_rd_vld  out  1  readback strobe (US_PARAM_READBACK_EN only)

## Operation
- A command is taken when i_cmd_vld=1, [31]==i_hw_ch, and the channel is < NUM_CH. Otherwise it is ignored silently.
- Write opcodes affect the staging bank only: 1 scan_len[10:0], 2 ainc_one[19:0], 3 ainc_two[19:0], 4 vrc_len[15:0], 5 accum[7:0], 6 delay[15:0], 7 scan_type[2:0], 9 start_amp[10:0], A amp_porch[9:0], B sel[2:0].
- Opcode C is commit. If payload[0]=0, staging[ch] is copied to active[ch] in one cycle. If payload[0]=1, a sweep starts that copies channel 0..NUM_CH-1, one per cycle.
- Opcode E is restore. Both banks are set to defaults in one cycle, and any sweep is aborted.
- Opcode D is readback, available only with US_PARAM_READBACK_EN.
- Any other opcode pulses o_cmd_err.
- Defaults per channel: accum 10, delay 0, scan_type 1, scan_len 64, sel=channel index, start_amp 0, amp_porch 40, ainc_one {20,0}, ainc_two {8,0}, vrc_len 150.
- FSM states:
  - IDLE: a commit-all command goes to SWEEP with ptr=0.
  - SWEEP: copies active[ptr]<=staging[ptr] and increments ptr. After ptr=NUM_CH-1, returns to IDLE. Restore also returns to IDLE.
- Any commit (single or all) received in SWEEP is rejected: o_cmd_err pulses. Writes are still accepted in SWEEP.
- Writes to staging[ptr] in the same cycle that ptr is copied land in staging only; the copy takes the pre-write value.
- Load in IDLE: outputs <= active[i_sub_channel].
- Load in SWEEP: the request is held in a 1-deep pending register; a newer load overwrites it. The pending load is served in the first IDLE cycle.
- A load and a single commit of the same channel in the same cycle: the load returns the pre-commit active value.

## Timing
- Reset: both banks hold defaults; outputs equal channel 0 defaults; o_ready=1; o_param_vld, o_cmd_err, o_rd_vld = 0; o_rd_data=0; FSM in IDLE; pending cleared.
- Load latency is 1 cycle: outputs and o_param_vld are valid on the edge after the i_load_param cycle.
- Write to staging: 1 cycle. Single commit: active is visible to a load issued 1 cycle later.
- A sweep takes NUM_CH cycles; o_ready=0 from the cycle after the commit-all is accepted through the last copy cycle.
- A pending load completes 1 cycle after o_ready returns to 1.
- Asserting rst_n mid-sweep returns everything to reset state; a pending load is lost.

## Configuration
- US_PARAM_READBACK_EN defined: opcode D with payload[3:0] = field index (same codes as write opcodes) returns the active value. o_rd_data is zero-extended and returned with o_rd_vld after 1 cycle.
- Not defined: opcode D pulses o_cmd_err, and o_rd_data/o_rd_vld are tied to 0.

## Structure
- Package us_param_pkg holds:
  - struct us_param_t with the 10 fields (118 bits)
  - opcode localparams
  - default-set function taking the channel index
- Sub-module us_param_commit_fsm owns the IDLE/SWEEP state, the sweep pointer, o_ready and the pending load. Both banks and the output registers stay in the top level.

## Test plan
- Reset, then load ch 3 → sel=3, scan_len=64, vrc_len=150; o_param_vld pulses 1 cycle later.
- Write scan_len=200 to ch 2, then load ch 2 → scan_len=64. Single commit ch 2, then load → 200.
- NUM_CH=8 commit-all: o_ready is low for 8 cycles. A load of ch 5 at sweep cycle 2 completes 1 cycle after o_ready rises, with the committed value. A second commit during the sweep → o_cmd_err pulse.
- Command with [31]≠i_hw_ch → no bank change. Opcode F → o_cmd_err pulse.
- Restore in the middle of a sweep → o_ready rises next cycle; all channels read default values.
- With US_PARAM_READBACK_EN, read delay of ch 1 after committing 0x1234 → o_rd_data=0x00001234 with o_rd_vld 1 cycle later.
